// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port arbiter and sequencer for the 256x16 program memory.
// The memory is shared between the CPU instruction-fetch port (read-only) and
// the boot loader port (read/write). After reset, the block serves only the
// loader. When ld_done is seen, it moves to RUN and arbitrates cycle by cycle.
// Read data returns exactly one cycle after the grant.
//
// Optional feature: define IMEM_ARB_RR_EN to resolve RUN-state contention
// round-robin. With the macro undefined, the loader always wins.
module imem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_gnt,
    output logic               fetch_rvalid,
    output logic [DATA_W-1:0]  fetch_rdata,
    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_wdata,
    output logic               ld_gnt,
    output logic               ld_rvalid,
    output logic [DATA_W-1:0]  ld_rdata,
    input  logic               ld_done,
    output logic               boot,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 boot_q, boot_d;
    logic                 fetch_rd_q, fetch_rd_d;
    logic                 ld_rd_q, ld_rd_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic                 run;
    logic                 fetch_elig;
    logic                 ld_elig;
    logic                 contend;
    logic                 fetch_gnt_c;
    logic                 ld_gnt_c;

    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

`ifdef IMEM_ARB_RR_EN
    // 0 = favour fetch under contention, 1 = favour loader
    logic rr_q, rr_d;
`endif

    // Eligibility: loader always, fetch only in RUN; nothing while in reset
    always_comb begin
        run        = (state_q == ST_RUN);
        ld_elig    = ld_req & ~rst;
        fetch_elig = fetch_req & run & ~rst;
        contend    = ld_elig & fetch_elig;
    end

`ifdef IMEM_ARB_RR_EN
    // Grant selection with round-robin tie-break on contention cycles
    always_comb begin
        ld_gnt_c    = 1'b0;
        fetch_gnt_c = 1'b0;
        if (contend) begin
            ld_gnt_c    = rr_q;
            fetch_gnt_c = ~rr_q;
        end else begin
            ld_gnt_c    = ld_elig;
            fetch_gnt_c = fetch_elig;
        end
    end

    // Pointer moves only when both contended, to favour whoever just lost
    always_comb begin
        rr_d = rr_q;
        if (contend) begin
            rr_d = fetch_gnt_c;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Grant selection with fixed priority: loader beats fetch
    always_comb begin
        ld_gnt_c    = ld_elig;
        fetch_gnt_c = fetch_elig & ~ld_elig;
    end
`endif

    // Memory drive muxed from whichever requester holds the grant; zero when idle
    always_comb begin
        fetch_gnt = fetch_gnt_c;
        ld_gnt    = ld_gnt_c;
        mem_en    = fetch_gnt_c | ld_gnt_c;
        mem_we    = ld_gnt_c & ld_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt_c) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (fetch_gnt_c) begin
            mem_addr  = fetch_addr;
        end
    end

    // Next-state logic: BOOT exits on ld_done, RUN is left only through reset
    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        case (state_q)
            ST_BOOT: begin
                if (ld_done) begin
                    state_d = ST_RUN;
                    boot_d  = 1'b0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                boot_d  = 1'b0;
            end
            default: begin
                state_d = ST_BOOT;
                boot_d  = 1'b1;
            end
        endcase
    end

    // FSM state with registered boot flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
        end
    end

    // Owner tag: record which requester was granted a read (writes leave no tag)
    always_comb begin
        fetch_rd_d = fetch_gnt_c;
        ld_rd_d    = ld_gnt_c & ~ld_we;
    end

    // Owner tag register; reset drops any outstanding read response
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_rd_q <= 1'b0;
            ld_rd_q    <= 1'b0;
        end else begin
            fetch_rd_q <= fetch_rd_d;
            ld_rd_q    <= ld_rd_d;
        end
    end

    // Read response steering: only the owner sees memory data
    always_comb begin
        fetch_rvalid = fetch_rd_q;
        ld_rvalid    = ld_rd_q;
        fetch_rdata  = fetch_rd_q ? mem_rdata : '0;
        ld_rdata     = ld_rd_q ? mem_rdata : '0;
        boot         = boot_q;
    end

    // Stall counter: count cycles with a fetch request but no grant, saturating
    always_comb begin
        stall_d = stall_q;
        if (fetch_req && !fetch_gnt_c && !(&stall_q)) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a small behavioural 256x16 memory.
// Uses STALL_W=4 so saturation of the stall counter is reachable quickly.
module tb_imem_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int STALL_W = 4;

    logic               clk;
    logic               rst;
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_gnt;
    logic               fetch_rvalid;
    logic [DATA_W-1:0]  fetch_rdata;
    logic               ld_req;
    logic               ld_we;
    logic [ADDR_W-1:0]  ld_addr;
    logic [DATA_W-1:0]  ld_wdata;
    logic               ld_gnt;
    logic               ld_rvalid;
    logic [DATA_W-1:0]  ld_rdata;
    logic               ld_done;
    logic               boot;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic [STALL_W-1:0] stall_cnt;

    logic [DATA_W-1:0]  mem [0:(1<<ADDR_W)-1];

    int n_checks;
    int n_errors;

    imem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STALL_W(STALL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata (fetch_rdata),
        .ld_req      (ld_req),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_gnt      (ld_gnt),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .ld_done     (ld_done),
        .boot        (boot),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port memory, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ef;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = '0;
        ld_req     = 1'b1;
        ld_we      = 1'b1;
        ld_addr    = 8'h10;
        ld_wdata   = 16'hAAAA;
        ld_done    = 1'b0;
        #1;
        // Nothing is granted while in reset
        check("rst_fetch_gnt", fetch_gnt, 0);
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        step();
        step();
        rst       = 1'b0;
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        ld_we     = 1'b0;
        #1;
        check("rst_boot", boot, 1);
        check("rst_stall", stall_cnt, 0);
        check("rst_fetch_rvalid", fetch_rvalid, 0);
        check("rst_ld_rvalid", ld_rvalid, 0);
        check("idle_mem_en", mem_en, 0);
        check("idle_mem_addr", mem_addr, 0);
        check("idle_mem_wdata", mem_wdata, 0);

        // Fetch held off in BOOT for 10 cycles
        fetch_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("boot_fetch_gnt", fetch_gnt, 0);
            step();
        end
        fetch_req = 1'b0;
        #1;
        check("boot_stall10", stall_cnt, 10);
        check("boot_still", boot, 1);

        // Loader write 0x1234 -> 0x05
        ld_req   = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 8'h05;
        ld_wdata = 16'h1234;
        #1;
        check("ldw_gnt", ld_gnt, 1);
        check("ldw_mem_en", mem_en, 1);
        check("ldw_mem_we", mem_we, 1);
        check("ldw_mem_addr", mem_addr, 8'h05);
        check("ldw_mem_wdata", mem_wdata, 16'h1234);
        step();
        ld_req = 1'b0;
        ld_we  = 1'b0;
        #1;
        check("ldw_no_rvalid", ld_rvalid, 0);

        // Loader read of 0x05 together with ld_done
        ld_req  = 1'b1;
        ld_done = 1'b1;
        #1;
        check("ldr_gnt", ld_gnt, 1);
        check("ldr_mem_we", mem_we, 0);
        check("ldr_boot_before", boot, 1);
        step();
        ld_req  = 1'b0;
        ld_done = 1'b0;
        #1;
        check("ldr_rvalid", ld_rvalid, 1);
        check("ldr_rdata", ld_rdata, 16'h1234);
        check("ldr_fetch_rdata0", fetch_rdata, 0);
        check("run_boot", boot, 0);

        // Fetch read of 0x05 in RUN
        fetch_req  = 1'b1;
        fetch_addr = 8'h05;
        #1;
        check("fr_gnt", fetch_gnt, 1);
        check("fr_mem_addr", mem_addr, 8'h05);
        check("fr_mem_we", mem_we, 0);
        step();
        fetch_req = 1'b0;
        #1;
        check("fr_rvalid", fetch_rvalid, 1);
        check("fr_rdata", fetch_rdata, 16'h1234);
        check("fr_ld_rvalid", ld_rvalid, 0);
        check("fr_ld_rdata0", ld_rdata, 0);
        check("fr_stall", stall_cnt, 10);

        // Loader write then fetch read of the same address next cycle
        ld_req   = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 8'h22;
        ld_wdata = 16'hBEEF;
        step();
        ld_req     = 1'b0;
        ld_we      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 8'h22;
        #1;
        check("wr_fr_gnt", fetch_gnt, 1);
        step();
        fetch_req = 1'b0;
        #1;
        check("wr_fr_rvalid", fetch_rvalid, 1);
        check("wr_fr_rdata", fetch_rdata, 16'hBEEF);

        // Contention: both reading every cycle for 4 cycles
        fetch_addr = 8'h05;
        ld_addr    = 8'h22;
        ld_we      = 1'b0;
        fetch_req  = 1'b1;
        ld_req     = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef IMEM_ARB_RR_EN
            ef = ((i % 2) == 0);
`else
            ef = 1'b0;
`endif
            #1;
            check("ct_fetch_gnt", fetch_gnt, ef);
            check("ct_ld_gnt", ld_gnt, !ef);
            step();
            check("ct_fetch_rvalid", fetch_rvalid, ef);
            check("ct_fetch_rdata", fetch_rdata, ef ? 16'h1234 : 16'h0);
            check("ct_ld_rvalid", ld_rvalid, !ef);
            check("ct_ld_rdata", ld_rdata, ef ? 16'h0 : 16'hBEEF);
        end
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        #1;
`ifdef IMEM_ARB_RR_EN
        check("ct_stall", stall_cnt, 12);
`else
        check("ct_stall", stall_cnt, 14);
`endif

        // Reset while a fetch read is outstanding
        fetch_req  = 1'b1;
        fetch_addr = 8'h05;
        #1;
        check("rr_fetch_gnt", fetch_gnt, 1);
        step();
        fetch_req = 1'b0;
        rst       = 1'b1;
        step();
        check("rr_fetch_rvalid", fetch_rvalid, 0);
        check("rr_boot", boot, 1);
        check("rr_stall", stall_cnt, 0);
        rst = 1'b0;

        // Stall counter saturation in BOOT
        fetch_req = 1'b1;
        repeat (15) step();
        check("sat_at15", stall_cnt, 4'hF);
        repeat (5) step();
        check("sat_at20", stall_cnt, 4'hF);
        check("sat_boot", boot, 1);
        fetch_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port arbiter and sequencer for the 256×16 program memory. It shares the memory between two requesters:
- the CPU instruction-fetch port (read-only);
- the boot loader port (read/write), which fills the memory at start-up.

After reset the block holds the CPU off until the loader signals completion. It then arbitrates cycle by cycle between the two requesters and returns read data with a fixed one-cycle latency.

## Interface
Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, memory word width
- STALL_W, 16, width of fetch-stall counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- fetch_req  in  1  CPU requests a read this cycle
- fetch_addr  in  ADDR_W  CPU read address
- fetch_gnt  out  1  CPU request accepted this cycle (combinational)
- fetch_rvalid  out  1  fetch_rdata valid (registered)
- fetch_rdata  out  DATA_W  read data to CPU
- ld_req  in  1  loader requests an access
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted (combinational)
- ld_rvalid  out  1  ld_rdata valid (registered)
- ld_rdata  out  DATA_W  read data to loader
- ld_done  in  1  single-cycle pulse: image load complete
- boot  out  1  1 while in BOOT state
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0
- stall_cnt  out  STALL_W  saturating count of fetch-stall cycles

## Operation
FSM states and transitions:
- BOOT: entered on reset. Only the loader is served. fetch_gnt is 0. ld_done moves the FSM to RUN on the next edge.
- RUN: both requesters are served. ld_done is ignored. The FSM leaves RUN only on rst.

Grant rules (at most one grant per cycle):
- If only one requester asserts req and is eligible, it is granted.
- If both assert req in RUN, the loader wins (fixed priority; see Configuration for the alternative).
- A req without a gnt must be held stable by the requester until granted.

Memory drive:
- mem_en = fetch_gnt | ld_gnt.
- mem_addr and mem_wdata are muxed from the granted requester.
- mem_we = ld_gnt & ld_we.
- When idle, mem_addr and mem_wdata are 0.

Read response:
- A registered owner tag records which requester was granted a read.
- The next cycle, the matching rvalid is 1 and its rdata = mem_rdata.
- The non-owner's rdata is 0.
- Writes produce no rvalid.

Stall counter:
- stall_cnt increments every cycle in which fetch_req=1 and fetch_gnt=0. This includes stalls during BOOT.
- It saturates at all-ones and is cleared only by rst.

## Timing
- Reset values: state=BOOT, boot=1, fetch_rvalid=0, ld_rvalid=0, owner tag cleared, stall_cnt=0, RR pointer = favour fetch.
- While rst=1, fetch_gnt, ld_gnt, mem_en and mem_we are 0.
- gnt and mem_* outputs are combinational from req, state and RR pointer. They have zero-cycle latency.
- Read latency is exactly 1 cycle from gnt to rvalid. Back-to-back reads sustain one per cycle, including alternating owners.
- ld_done and ld_req in the same cycle: the access is granted in BOOT, and the state becomes RUN on the next edge.
- A reset asserted while a read is outstanding suppresses its rvalid on the following cycle.
- A loader write followed by a fetch read of the same address on the next cycle returns the new data. The memory write completes at the edge.

## Configuration
- IMEM_ARB_RR_EN defined: in RUN, simultaneous requests are resolved round-robin.
  - A 1-bit pointer favours the requester that was not last granted under contention.
  - The pointer updates only on contention cycles.
  - The pointer resets to favour fetch.
  - BOOT behaviour is unchanged.
- IMEM_ARB_RR_EN undefined: fixed priority, loader always wins. The pointer logic is absent.

## Test plan
- Reset, fetch_req=1 in BOOT for 10 cycles -> fetch_gnt=0 throughout, stall_cnt=10, boot=1.
- Loader writes 0x1234 to addr 0x05, pulses ld_done, then fetch reads 0x05 -> boot=0 after the pulse; fetch_rvalid=1 one cycle after the grant with fetch_rdata=0x1234.
- RUN, both requesters reading every cycle for 4 cycles:
  - fixed priority -> ld_gnt=1 all 4 cycles and stall_cnt +4;
  - with IMEM_ARB_RR_EN -> grants alternate fetch, ld, fetch, ld.
- Loader write, ld_we=1 -> mem_we=1 and mem_en=1 in the grant cycle, and no ld_rvalid on the next cycle.
- Fetch read granted, then rst asserted in the following cycle -> fetch_rvalid=0, state=BOOT, stall_cnt=0.
- Force stall_cnt to saturate (STALL_W=4, 20 stall cycles) -> stall_cnt holds 0xF.
